// File: rtl/dp_ram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// dp_ram_fifo_ctrl
//
// Port-side controller for a dual-port RAM. It drives the RAM write and read
// ports, which makes the RAM a single-clock FIFO with valid/ready push and
// pop handshakes. Both RAM clocks are tied to this block's clock. The RAM
// read data is registered, so a 2-entry skid buffer sits on the output. It
// holds prefetched words so the FIFO sustains one word per cycle.
//
// Optional feature, enabled by defining the macro DPRAM_FIFO_LEVEL_EN:
//   adds the registered `level` (total occupancy) and `almost_full` outputs.
//
// Ports
//   clock        in   1             single clock (also RAM write/read clock)
//   rst_n        in   1             asynchronous active-low reset
//   in_valid     in   1             push request
//   in_ready     out  1             push accept (RAM not full)
//   in_data      in   RAM_WIDTH     push data
//   out_valid    out  1             pop data available
//   out_ready    in   1             pop accept
//   out_data     out  RAM_WIDTH     head-of-FIFO data
//   write_allow  out  1             RAM write enable
//   write_addr   out  ADDR_WIDTH    RAM write address
//   write_data   out  RAM_WIDTH     RAM write data
//   read_allow   out  1             RAM read enable
//   read_addr    out  ADDR_WIDTH    RAM read address
//   read_data    in   RAM_WIDTH     RAM read data, valid 1 cycle after read_allow
//   level        out  ADDR_WIDTH+2  total occupancy      (DPRAM_FIFO_LEVEL_EN)
//   almost_full  out  1             level >= AFULL_THRESH (DPRAM_FIFO_LEVEL_EN)
// ---------------------------------------------------------------------------
module dp_ram_fifo_ctrl #(
    parameter int RAM_WIDTH    = 8,
    parameter int RAM_DEPTH    = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [RAM_WIDTH-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RAM_WIDTH-1:0]  out_data,
    output logic                  write_allow,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [RAM_WIDTH-1:0]  write_data,
    output logic                  read_allow,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [RAM_WIDTH-1:0]  read_data
`ifdef DPRAM_FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  almost_full
`endif
);

    localparam int PTR_W   = ADDR_WIDTH + 1;
    localparam int LEVEL_W = ADDR_WIDTH + 2;

    // A depth that is not 2**ADDR_WIDTH would alias RAM addresses, and a
    // threshold above the total capacity could never fire. Such an instance
    // refuses every push so the misconfiguration is obvious at once.
    localparam bit CFG_OK = (RAM_DEPTH == (1 << ADDR_WIDTH)) &&
                            (AFULL_THRESH <= RAM_DEPTH + 2);

    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr_nxt;
    logic [PTR_W-1:0]     rd_ptr_nxt;
    logic                 ready_en;
    logic                 ram_empty;
    logic                 ram_full;
    logic                 pop;
    logic [2:0]           skid_demand;

    logic                 inflight;
    logic [1:0]           skid_cnt;
    logic [1:0]           skid_cnt_nxt;
    logic                 skid_hd;
    logic                 skid_tl;
    logic [RAM_WIDTH-1:0] skid_mem [2];

    // ------------------------------------------------------------------
    // Push side and RAM read issue (combinational)
    // ------------------------------------------------------------------
    assign ram_empty = (wr_ptr == rd_ptr);
    assign ram_full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                       (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

    // ready_en keeps in_ready low while reset is held. in_ready looks only at
    // RAM occupancy, so a pop while full frees space on the next cycle only.
    assign in_ready    = ready_en & ~ram_full & CFG_OK;
    assign write_allow = in_valid & in_ready;
    assign write_addr  = wr_ptr[ADDR_WIDTH-1:0];
    assign write_data  = in_data;

    assign pop = out_valid & out_ready;

    // Words already promised to the skid: those held in it plus the one in
    // flight from the RAM, less the one leaving this cycle. Issue a read only
    // if the word has a guaranteed slot.
    assign skid_demand = {1'b0, skid_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign read_allow  = ~ram_empty & (skid_demand < 3'd2);
    assign read_addr   = rd_ptr[ADDR_WIDTH-1:0];

    always_comb begin
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        skid_cnt_nxt = skid_cnt;
        if (write_allow) begin
            wr_ptr_nxt = wr_ptr + PTR_W'(1);
        end
        if (read_allow) begin
            rd_ptr_nxt = rd_ptr + PTR_W'(1);
        end
        // A capture and a pop in the same cycle leave the count unchanged.
        if (inflight && !pop) begin
            skid_cnt_nxt = skid_cnt + 2'd1;
        end else if (!inflight && pop) begin
            skid_cnt_nxt = skid_cnt - 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Control registers: pointers, in-flight flag, skid bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
            skid_cnt <= 2'd0;
            skid_hd  <= 1'b0;
            skid_tl  <= 1'b0;
            ready_en <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            inflight <= read_allow;
            skid_cnt <= skid_cnt_nxt;
            skid_hd  <= skid_hd ^ pop;
            skid_tl  <= skid_tl ^ inflight;
            ready_en <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Skid storage: the RAM word is present during the inflight cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (inflight) begin
            skid_mem[skid_tl] <= read_data;
        end
    end

    assign out_valid = (skid_cnt != 2'd0);
    assign out_data  = skid_mem[skid_hd];

`ifdef DPRAM_FIFO_LEVEL_EN
    logic [PTR_W-1:0]   ram_used_nxt;
    logic [LEVEL_W-1:0] level_nxt;

    // Occupancy is computed from next-state values, so the registered level
    // matches the state that the same edge produces.
    always_comb begin
        ram_used_nxt = wr_ptr_nxt - rd_ptr_nxt;
        level_nxt    = LEVEL_W'(ram_used_nxt) + LEVEL_W'(read_allow) +
                       LEVEL_W'(skid_cnt_nxt);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            level       <= '0;
            almost_full <= 1'b0;
        end else begin
            level       <= level_nxt;
            almost_full <= (level_nxt >= LEVEL_W'(AFULL_THRESH));
        end
    end
`endif

endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
module tb_dp_ram_fifo_ctrl;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [7:0] read_data = 8'h00;
    wire        in_ready;
    wire        out_valid;
    wire  [7:0] out_data;
    wire        write_allow;
    wire  [3:0] write_addr;
    wire  [7:0] write_data;
    wire        read_allow;
    wire  [3:0] read_addr;
`ifdef DPRAM_FIFO_LEVEL_EN
    wire  [5:0] level;
    wire        almost_full;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    dp_ram_fifo_ctrl #(
        .RAM_WIDTH(8), .RAM_DEPTH(16), .ADDR_WIDTH(4), .AFULL_THRESH(12)
    ) dut (
`ifdef DPRAM_FIFO_LEVEL_EN
        .level(level),
        .almost_full(almost_full),
`endif
        .clock(clock),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .write_allow(write_allow),
        .write_addr(write_addr),
        .write_data(write_data),
        .read_allow(read_allow),
        .read_addr(read_addr),
        .read_data(read_data)
    );

    always #5 clock = ~clock;

    // Dual-port RAM with registered read data.
    logic [7:0] ram_mem [16];
    int         ram_cnt;

    always @(posedge clock) begin
        if (write_allow) ram_mem[write_addr] <= write_data;
        if (read_allow)  read_data <= ram_mem[read_addr];
    end

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) ram_cnt <= 0;
        else        ram_cnt <= ram_cnt + int'(write_allow) - int'(read_allow);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // RAM port safety, observed on every cycle where a port is active.
    always @(negedge clock) begin
        if (rst_n) begin
            if (write_allow) chk("wa_while_ram_full", 32'(ram_cnt < 16), 1);
            if (read_allow)  chk("ra_while_ram_empty", 32'(ram_cnt > 0), 1);
            if (write_allow && read_allow)
                chk("rd_wr_same_addr", 32'(write_addr != read_addr), 1);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 8'h00;
        rst_n     = 1'b0;
        cyc();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_write_allow", write_allow, 0);
        chk("rst_read_allow", read_allow, 0);
        rst_n = 1'b1;
        cyc();
    endtask

    typedef struct {
        logic       iv;
        logic       ordy;
        logic [7:0] din;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_wa;
        logic [3:0] e_wadr;
        logic       e_ra;
        logic [3:0] e_radr;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, sent, recv, gaps, lat;
        bit started;

        //         iv   ordy din    ir   ov   od     wa   wadr  ra   radr
        tbl[0]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 4'd0};
        tbl[1]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 4'd0};
        tbl[2]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 4'd0};
        tbl[3]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b0, 4'd0, 1'b0, 4'd0};
        tbl[4]  = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 8'h00, 1'b1, 4'd1, 1'b0, 4'd0};
        tbl[5]  = '{1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 8'h00, 1'b1, 4'd2, 1'b1, 4'd1};
        tbl[6]  = '{1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 8'h00, 1'b1, 4'd3, 1'b1, 4'd2};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b0, 4'd0, 1'b0, 4'd0};
        tbl[8]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h11, 1'b0, 4'd0, 1'b1, 4'd3};
        tbl[9]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h22, 1'b0, 4'd0, 1'b0, 4'd0};
        tbl[10] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h33, 1'b0, 4'd0, 1'b0, 4'd0};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 4'd0};

        // T1 plus skid fill/drain: per-cycle table.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            in_valid  = tbl[i].iv;
            out_ready = tbl[i].ordy;
            in_data   = tbl[i].din;
            @(negedge clock);
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_ir);
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
            chk($sformatf("tbl%0d_write_allow", i), write_allow, tbl[i].e_wa);
            chk($sformatf("tbl%0d_read_allow", i), read_allow, tbl[i].e_ra);
            if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_od);
            if (tbl[i].e_wa) chk($sformatf("tbl%0d_write_addr", i), write_addr, tbl[i].e_wadr);
            if (tbl[i].e_ra) chk($sformatf("tbl%0d_read_addr", i), read_addr, tbl[i].e_radr);
            cyc();
        end

        // T2: capacity with the output stalled.
        do_reset();
        n = 0;
        for (int c = 0; c < 40; c++) begin
            in_valid = (n < 20);
            in_data  = 8'(n);
            @(negedge clock);
            if (in_valid && in_ready) n++;
            cyc();
        end
        in_valid = 1'b0;
        chk("t2_accepted", n, 18);
        @(negedge clock);
        chk("t2_in_ready_full", in_ready, 0);
`ifdef DPRAM_FIFO_LEVEL_EN
        chk("t2_level", level, 18);
`endif
        cyc();
        out_ready = 1'b1;
        @(negedge clock);
        chk("t2_pop_full_in_ready", in_ready, 0);
        chk("t2_pop_full_out_valid", out_valid, 1);
        recv = 0;
        for (int c = 0; c < 60 && recv < 18; c++) begin
            if (c != 0) @(negedge clock);
            if (out_valid) begin
                chk($sformatf("t2_word%0d", recv), out_data, 32'(recv));
                recv++;
            end
            cyc();
        end
        chk("t2_drained", recv, 18);
        @(negedge clock);
        chk("t2_empty_after", out_valid, 0);
        cyc();

        // T3: sustained throughput.
        do_reset();
        sent = 0; recv = 0; gaps = 0; started = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 300 && recv < 100; c++) begin
            in_valid = (sent < 100);
            in_data  = 8'(sent);
            @(negedge clock);
            if (in_valid && in_ready) sent++;
            if (out_valid) begin
                chk($sformatf("t3_word%0d", recv), out_data, 32'(recv));
                recv++;
                started = 1;
            end else if (started) begin
                gaps++;
            end
            cyc();
        end
        in_valid = 1'b0;
        chk("t3_received", recv, 100);
        chk("t3_bubbles", gaps, 0);
        @(negedge clock);
        chk("t3_no_extra", out_valid, 0);
        cyc();

        // T4: random back-pressure, pointers wrap twice.
        do_reset();
        sent = 0; recv = 0;
        for (int c = 0; c < 600 && recv < 40; c++) begin
            in_valid  = (sent < 40);
            in_data   = 8'(8'h80 + sent);
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clock);
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                chk($sformatf("t4_word%0d", recv), out_data, 32'(8'h80 + recv));
                recv++;
            end
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t4_received", recv, 40);
        in_valid = 1'b1;
        @(negedge clock);
        chk("t4_wrapped_write_addr", write_addr, 8);
        in_valid = 1'b0;
        cyc();

        // T5: reset mid-operation discards queued words.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h40 + i);
            cyc();
        end
        in_valid = 1'b0;
        repeat (4) cyc();
        chk("t5_queued_valid", out_valid, 1);
        @(posedge clock);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_in_ready", in_ready, 0);
        @(posedge clock);
        #2 rst_n = 1'b1;
        cyc();
        chk("t5_after_in_ready", in_ready, 1);
        chk("t5_after_out_valid", out_valid, 0);
`ifdef DPRAM_FIFO_LEVEL_EN
        chk("t5_after_level", level, 0);
`endif
        in_valid  = 1'b1;
        in_data   = 8'h5C;
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            cyc();
            lat++;
        end
        chk("t5_latency", lat, 3);
        chk("t5_data", out_data, 8'h5C);
        cyc();
        chk("t5_alone", out_valid, 0);

`ifdef DPRAM_FIFO_LEVEL_EN
        // T6: almost_full threshold.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            @(negedge clock);
            if (i == 11) chk("t6_af_before", almost_full, 0);
            cyc();
        end
        in_valid = 1'b0;
        chk("t6_af_rise", almost_full, 1);
        chk("t6_level12", level, 12);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("t6_af_fall", almost_full, 0);
        chk("t6_level11", level, 11);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
